// File: rtl/calc_rr_engine_pkg.sv
// calc_pkg: shared encodings and the request FIFO entry for calc_rr_engine.
// Entry fields are sized for the widest legal configuration (DATA_W<=64,
// TAG_W<=8); the engine zero-extends into them and slices back out. The
// constant-zero upper bits carry no state in narrower builds.
package calc_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 8;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  // cmd is kept as raw bits: invalid opcodes must survive to the ALU.
  typedef struct packed {
    logic [3:0]            cmd;
    logic [MAX_DATA_W-1:0] op1;
    logic [MAX_DATA_W-1:0] op2;
    logic [MAX_TAG_W-1:0]  tag;
  } calc_entry_t;

endpackage

// File: rtl/calc_rr_engine_if.sv
// calc_rr_engine_if: flat per-port request/response bus of the engine.
//   req_cmd_in/req_data_in/req_tag_in : requester -> engine, port p at [p*W +: W]
//   out_resp/out_data/out_tag          : engine -> requester, one-cycle response
//   out_busy                           : port FIFO full
//   out_drop                           : sticky, a request was discarded
interface calc_rr_engine_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2
);
  logic [NUM_PORTS*4-1:0]      req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
  logic [NUM_PORTS*2-1:0]      out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS*TAG_W-1:0]  out_tag;
  logic [NUM_PORTS-1:0]        out_busy;
  logic [NUM_PORTS-1:0]        out_drop;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, out_busy, out_drop
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, out_busy, out_drop
  );
endinterface

// File: rtl/calc_req_fifo.sv
// calc_req_fifo: per-port synchronous request FIFO.
//   clk/rst   : clock, async active-high reset (empties the FIFO)
//   push/din  : enqueue; refused when full unless popping on the same edge
//   pop/dout  : dequeue, dout is the current head (show-ahead)
//   full/empty: occupancy flags from the registered count
module calc_req_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  calc_entry_t din,
  input  logic        pop,
  output calc_entry_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  calc_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO that pops this edge frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/calc_rr_engine.sv
// calc_rr_engine: NUM_PORTS requesters sharing one registered ALU.
//   c_clk : clock, rising edge
//   reset : async active-high, clears FIFOs, capture FSMs, rr pointer, outputs
//   bus   : calc_rr_engine_if slave (requests in, tagged responses/busy/drop out)
// Each port captures cmd/op1/tag, then op2 the next cycle, and enqueues the
// pair. A round-robin arbiter pops one head per cycle into the ALU whose
// result is registered onto the granted port's response slice for one cycle.
module calc_rr_engine
  import calc_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  calc_rr_engine_if.slave   bus
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SH_W  = $clog2(DATA_W);

  calc_entry_t            head [NUM_PORTS];
  logic [NUM_PORTS-1:0]   empty, full, pop, drop_set;
  logic [NUM_PORTS-1:0]   drop_q;

  // ---------------- per-port capture FSM + FIFO ----------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [3:0]        cmd_in;
    cap_state_e        st_q, st_d;
    logic              push;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_op1;
    logic [TAG_W-1:0]  cap_tag;
    calc_entry_t       din;

    assign cmd_in = bus.req_cmd_in[p*4 +: 4];

    always_comb begin
      st_d = st_q;
      push = 1'b0;
      case (st_q)
        CAP_IDLE: if (cmd_in != CMD_NOP) st_d = CAP_OP2;
        CAP_OP2: begin
          push = 1'b1;
          st_d = CAP_IDLE;
        end
        default: st_d = CAP_IDLE;
      endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) st_q <= CAP_IDLE;
      else       st_q <= st_d;
    end

    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        cap_cmd <= '0;
        cap_op1 <= '0;
        cap_tag <= '0;
      end else if (st_q == CAP_IDLE && cmd_in != CMD_NOP) begin
        cap_cmd <= cmd_in;
        cap_op1 <= bus.req_data_in[p*DATA_W +: DATA_W];
        cap_tag <= bus.req_tag_in[p*TAG_W +: TAG_W];
      end
    end

    // op2 goes straight from the bus into the FIFO on the enqueue edge.
    always_comb begin
      din     = '0;
      din.cmd = cap_cmd;
      din.op1 = MAX_DATA_W'(cap_op1);
      din.op2 = MAX_DATA_W'(bus.req_data_in[p*DATA_W +: DATA_W]);
      din.tag = MAX_TAG_W'(cap_tag);
    end

    assign drop_set[p] = push && full[p] && !pop[p];

    calc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (c_clk),
      .rst   (reset),
      .push  (push),
      .din   (din),
      .pop   (pop[p]),
      .dout  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  // ---------------- round-robin arbiter ----------------
  logic [PTR_W-1:0] rr_ptr, gnt_idx;
  logic             gnt_vld;
  int               scan;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!gnt_vld && !empty[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(scan);
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pop
    assign pop[p] = gnt_vld && (gnt_idx == PTR_W'(p));
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset)        rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + 1'b1;
  end

  // ---------------- ALU ----------------
  calc_entry_t       gnt_entry;
  logic [DATA_W-1:0] a, b, alu_data;
  logic [DATA_W:0]   sum;
  resp_e             alu_resp;
  logic              unused_entry;

  assign gnt_entry    = head[gnt_idx];
  assign a            = gnt_entry.op1[DATA_W-1:0];
  assign b            = gnt_entry.op2[DATA_W-1:0];
  assign sum          = {1'b0, a} + {1'b0, b};
  assign unused_entry = ^gnt_entry;

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (gnt_entry.cmd)
      CMD_ADD: if (!sum[DATA_W]) begin
        alu_resp = RESP_OK;
        alu_data = sum[DATA_W-1:0];
      end
      CMD_SUB: if (b <= a) begin
        alu_resp = RESP_OK;
        alu_data = a - b;
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = a << b[SH_W-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = a >> b[SH_W-1:0];
      end
      default: ;
    endcase
  end

  // ---------------- response demux register ----------------
  logic [NUM_PORTS-1:0][1:0]        resp_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_q;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  tag_q;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      drop_q <= '0;
    end else begin
      // Every slice clears each cycle so a response lasts exactly one cycle.
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      if (gnt_vld) begin
        resp_q[gnt_idx] <= alu_resp;
        data_q[gnt_idx] <= alu_data;
        tag_q[gnt_idx]  <= gnt_entry.tag[TAG_W-1:0];
      end
      drop_q <= drop_q | drop_set;
    end
  end

  assign bus.out_resp = resp_q;
  assign bus.out_data = data_q;
  assign bus.out_tag  = tag_q;
  assign bus.out_busy = full;
  assign bus.out_drop = drop_q;
endmodule
